// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam logic [ADDR_W-1:0] DEF_EXC_VEC  = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_FULL
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// sram-like instruction memory port; master = fetch controller, slave = memory.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/fetch_ctrl_redirect_sel.sv
// Picks the winning redirect of the cycle: exception, then eret, then branch.
module redirect_sel
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic              flush_exc,
  input  logic              flush_eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_target
);

  always_comb begin
    redirect_valid  = flush_exc | flush_eret | br_taken;
    redirect_target = br_target;
    if (flush_exc) begin
      redirect_target = EXC_VEC;
    end else if (flush_eret) begin
      redirect_target = epc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding sram-like request feeding a
// one-deep fetch buffer, with redirect handling that squashes stale data.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush_exc,
  input  logic              flush_eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  fetch_ctrl_if.master      mem,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst
);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic              discard_reg;
  logic              inst_req_reg;
  logic              if_valid_reg;
  logic [ADDR_W-1:0] if_pc_reg;
  logic [31:0]       if_inst_reg;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;

  redirect_sel #(.EXC_VEC(EXC_VEC)) u_redirect_sel (
    .flush_exc       (flush_exc),
    .flush_eret      (flush_eret),
    .epc             (epc),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_BOOT;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      discard_reg  <= 1'b0;
      inst_req_reg <= 1'b0;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= '0;
      if_inst_reg  <= '0;
    end else begin
      // Redirects always retarget fetch_pc (except in BOOT); a normal
      // buffer load below overrides this only when no redirect is present.
      if (redirect_valid && state_reg != ST_BOOT) begin
        fetch_pc_reg <= redirect_target;
      end
      case (state_reg)
        ST_BOOT: begin
          state_reg    <= ST_REQ;
          req_addr_reg <= fetch_pc_reg;
          inst_req_reg <= 1'b1;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            discard_reg <= 1'b1;
          end
          if (mem.inst_addr_ok) begin
            state_reg    <= ST_WAIT;
            inst_req_reg <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem.inst_data_ok) begin
            if (redirect_valid) begin
              discard_reg  <= 1'b0;
              req_addr_reg <= redirect_target;
              state_reg    <= ST_REQ;
              inst_req_reg <= 1'b1;
            end else if (discard_reg) begin
              discard_reg  <= 1'b0;
              req_addr_reg <= fetch_pc_reg;
              state_reg    <= ST_REQ;
              inst_req_reg <= 1'b1;
            end else begin
              if_valid_reg <= 1'b1;
              if_pc_reg    <= req_addr_reg;
              if_inst_reg  <= mem.inst_rdata;
              fetch_pc_reg <= seq_pc(req_addr_reg);
              state_reg    <= ST_FULL;
            end
          end else if (redirect_valid) begin
            discard_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          if (redirect_valid) begin
            if_valid_reg <= 1'b0;
            req_addr_reg <= redirect_target;
            state_reg    <= ST_REQ;
            inst_req_reg <= 1'b1;
          end else if (!stall) begin
            if_valid_reg <= 1'b0;
            req_addr_reg <= fetch_pc_reg;
            state_reg    <= ST_REQ;
            inst_req_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_BOOT;
          inst_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem.inst_req  = inst_req_reg;
  assign mem.inst_addr = req_addr_reg;
  assign if_valid      = if_valid_reg;
  assign if_pc         = if_pc_reg;
  assign if_inst       = if_inst_reg;

endmodule
